// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: COLS_PER_CYCLE columns per clock, valid/ready in and out.
// Optional MIX_COLUMNS_INV_EN adds an inv port selecting InvMixColumns.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
`ifdef MIX_COLUMNS_INV_EN
  ,
  input  logic         inv
`endif
);

  // state | meaning
  // IDLE  | waiting for a state, in_ready high
  // BUSY  | rewriting COLS_PER_CYCLE columns per clock in the working register
  // DONE  | result held on out_state until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         LAST_I = 4 - COLS_PER_CYCLE;
  localparam logic [1:0] STEP   = COLS_PER_CYCLE[1:0];
  localparam logic [1:0] LAST   = LAST_I[1:0];

  state_t       state;
  logic [1:0]   col_cnt;
  logic [0:127] work;
  logic [0:127] work_nxt;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
            m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
            md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
            mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
  endfunction
`endif

  // col_cnt is always a multiple of COLS_PER_CYCLE, so col_cnt+k stays within 0..3
  always_comb begin
    work_nxt = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIX_COLUMNS_INV_EN
      if (inv_q)
        work_nxt[32*(int'(col_cnt)+k) +: 32] = inv_col(work[32*(int'(col_cnt)+k) +: 32]);
      else
        work_nxt[32*(int'(col_cnt)+k) +: 32] = fwd_col(work[32*(int'(col_cnt)+k) +: 32]);
`else
      work_nxt[32*(int'(col_cnt)+k) +: 32] = fwd_col(work[32*(int'(col_cnt)+k) +: 32]);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col_cnt   <= 2'd0;
      work      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            work     <= in_state;
            col_cnt  <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
`ifdef MIX_COLUMNS_INV_EN
            inv_q    <= inv;
`endif
          end
        end
        BUSY: begin
          work    <= work_nxt;
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_state = work;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per clock) on shared stimulus,
// checked every cycle against a GF(2^8) matrix model. Honours MIX_COLUMNS_INV_EN.
module tb_mix_columns_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] in_state = '0;
  logic         inv = 1'b0;
  logic [2:0]   in_ready, out_valid, busy;
  logic [0:127] out_state [3];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_state(out_state[0]), .busy(busy[0])
`ifdef MIX_COLUMNS_INV_EN
    , .inv(inv)
`endif
  );

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_state(out_state[1]), .busy(busy[1])
`ifdef MIX_COLUMNS_INV_EN
    , .inv(inv)
`endif
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_state(in_state), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_state(out_state[2]), .busy(busy[2])
`ifdef MIX_COLUMNS_INV_EN
    , .inv(inv)
`endif
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [0:127] mix_model(input logic [0:127] s, input logic do_inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [0:127] res = '0;
    if (do_inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[c*32+j*8 +: 8], coef[(j - r + 4) % 4]);
        res[c*32+r*8 +: 8] = acc;
      end
    return res;
  endfunction

  int           lat [3] = '{4, 2, 1};
  logic         m_rdy [3], m_ov [3], m_busy [3], m_act [3];
  int           m_cnt [3];
  logic [0:127] m_exp [3];

  // Handshake model: result appears lat edges after accept, leaves one edge after out_ready.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_rdy[i] = 1'b0; m_ov[i] = 1'b0; m_busy[i] = 1'b0; m_act[i] = 1'b0;
        m_cnt[i] = 0; m_exp[i] = '0;
      end else if (m_ov[i]) begin
        if (out_ready) begin
          m_ov[i] = 1'b0; m_busy[i] = 1'b0; m_rdy[i] = 1'b1;
        end
      end else if (m_act[i]) begin
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == lat[i]) begin
          m_ov[i] = 1'b1; m_act[i] = 1'b0;
        end
      end else if (m_rdy[i] && in_valid) begin
        m_rdy[i] = 1'b0; m_busy[i] = 1'b1; m_act[i] = 1'b1; m_cnt[i] = 0;
        m_exp[i] = mix_model(in_state, inv);
      end else begin
        m_rdy[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("c%0d in_ready", lat[i]), 128'(in_ready[i]), 128'(m_rdy[i]));
      chk($sformatf("c%0d out_valid", lat[i]), 128'(out_valid[i]), 128'(m_ov[i]));
      chk($sformatf("c%0d busy", lat[i]), 128'(busy[i]), 128'(m_busy[i]));
      if (!rst_n)
        chk($sformatf("c%0d out_state reset", lat[i]), out_state[i], 128'h0);
      else if (m_ov[i])
        chk($sformatf("c%0d out_state", lat[i]), out_state[i], m_exp[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [0:127] s, input logic iv);
    int t = 0;
    @(negedge clk);
    while (in_ready !== 3'b111 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_err++;
      $display("FAIL send timeout: in_ready %b required 111", in_ready);
    end
    in_state = s;
    inv      = iv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done();
    int t = 0;
    while (out_valid !== 3'b111 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_err++;
      $display("FAIL done timeout: out_valid %b required 111", out_valid);
    end
  endtask

  task automatic run(input string name, input logic [0:127] s, input logic iv,
                     input logic [0:127] exp);
    out_ready = 1'b0;
    send(s, iv);
    wait_done();
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s c%0d", name, lat[i]), out_state[i], exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    logic [0:127] s, y;

    chk("model fips", mix_model(FIPS_IN, 1'b0), FIPS_OUT);
    chk("model column", mix_model(128'hdb135345010101010101010101010101, 1'b0),
        128'h8e4da1bc010101010101010101010101);
    chk("model inverse", mix_model(FIPS_OUT, 1'b1), FIPS_IN);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("single column", 128'hdb135345010101010101010101010101, 1'b0,
        128'h8e4da1bc010101010101010101010101);
    run("fips round1", FIPS_IN, 1'b0, FIPS_OUT);
    run("corner bytes", 128'hc6c6c6c6d4d4d4d52d26314c00000000, 1'b0,
        128'hc6c6c6c6d5d5d7d64d7ebdf800000000);

    // backpressure with an ignored in_valid pulse while results are held
    out_ready = 1'b0;
    send(FIPS_IN, 1'b0);
    wait_done();
    repeat (4) @(negedge clk);
    in_state = 128'h0123456789abcdef0123456789abcdef;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("held c%0d", lat[i]), out_state[i], FIPS_OUT);
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready after release", 128'(in_ready), 128'h7);
    out_ready = 1'b0;

    // reset while busy, then a fresh state
    send(FIPS_IN, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async rst out_state c%0d", lat[i]), out_state[i], 128'h0);
      chk($sformatf("async rst flags c%0d", lat[i]),
          128'({in_ready[i], out_valid[i], busy[i]}), 128'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run("after reset", 128'hf20a225c01010101c6c6c6c6d4d4d4d5, 1'b0,
        128'h9fdc589d01010101c6c6c6c6d5d5d7d6);

    // out_ready held high in advance: model checks latency and single-cycle out_valid
    out_ready = 1'b1;
    send(128'h00112233445566778899aabbccddeeff, 1'b0);
    repeat (8) @(negedge clk);
    out_ready = 1'b0;

`ifdef MIX_COLUMNS_INV_EN
    run("inverse fips", FIPS_OUT, 1'b1, FIPS_IN);
    for (int n = 0; n < 3; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b0;
      send(s, 1'b0);
      wait_done();
      y = out_state[0];
      out_ready = 1'b1;
      @(negedge clk);
      run($sformatf("round trip %0d", n), y, 1'b1, s);
    end
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
